// File: rtl/pla_restrict_eval_if.sv
// Stream and configuration bus of the autosymmetric PLA evaluator.
interface pla_restrict_eval_if #(
  parameter int unsigned NI = 21,
  parameter int unsigned NR = 16,
  parameter int unsigned NC = 64,
  parameter int unsigned NO = 1,
  parameter int unsigned CW = 2 * NR + NO,
  parameter int unsigned AW = $clog2(NR + NC)
);
  // Input vector stream
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] x;

  // Result stream
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] y;

  // Configuration write port
  logic          cfg_we;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;

  // Completed output transfers
  logic [31:0]   eval_count;

  // Evaluator side
  modport slave (
    input  in_valid, x, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, y, cfg_ready, eval_count
  );

  // Source / sink side
  modport master (
    output in_valid, x, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, y, cfg_ready, eval_count
  );
endinterface

// File: rtl/pla_restrict_eval.sv
// Pipelined evaluator of y = g(A*x ^ c): a GF(2) reduction stage followed by
// a run-time loaded sum-of-products PLA, with valid/ready streams on both sides.
module pla_restrict_eval #(
  parameter int unsigned NI = 21,
  parameter int unsigned NR = 16,
  parameter int unsigned NC = 64,
  parameter int unsigned NO = 1,
  parameter int unsigned CW = 2 * NR + NO,
  parameter int unsigned AW = $clog2(NR + NC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pla_restrict_eval_if.slave   bus
);

  localparam int unsigned CNT_W = 32;

  // Transform table: row j computes r[j] = parity(x & mask_j) ^ invert_j
  logic [NI-1:0]    mask_q [NR];
  logic [NR-1:0]    inv_q;

  // Cube table
  logic [NR-1:0]    care_q  [NC];
  logic [NR-1:0]    value_q [NC];
  logic [NO-1:0]    omask_q [NC];
  logic [NC-1:0]    en_q;

  // Pipeline state; stage-2 valid is the output valid
  logic             s1_valid_q;
  logic [NR-1:0]    r_q;
  logic             out_valid_q;
  logic [NO-1:0]    y_q;
  logic [CNT_W-1:0] eval_count_q;

  // Combinational control and datapath
  logic             cfg_ready_c;
  logic             cfg_take_c;
  logic             s2_adv_c;
  logic             in_ready_c;
  logic             in_accept_c;
  logic             out_xfer_c;
  logic [NR-1:0]    r_d;
  logic [NC-1:0]    hit_c;
  logic [NO-1:0]    y_d;

  // Handshake: config only lands on an empty pipeline and beats a same-cycle input
  always_comb begin
    cfg_ready_c = ~s1_valid_q & ~out_valid_q;
    cfg_take_c  = bus.cfg_we & cfg_ready_c;
    s2_adv_c    = s1_valid_q & (~out_valid_q | bus.out_ready);
    in_ready_c  = (~s1_valid_q | s2_adv_c) & ~cfg_take_c;
    in_accept_c = bus.in_valid & in_ready_c;
    out_xfer_c  = out_valid_q & bus.out_ready;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.cfg_ready  = cfg_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.y          = y_q;
  assign bus.eval_count = eval_count_q;

  // Transform rows: identity on reset, overwritten by row-addressed config writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NR; j++) begin
        mask_q[j] <= NI'(1) << j;
      end
      inv_q <= '0;
    end else if (cfg_take_c) begin
      for (int unsigned j = 0; j < NR; j++) begin
        if (bus.cfg_addr == AW'(j)) begin
          mask_q[j] <= bus.cfg_data[NI-1:0];
          inv_q[j]  <= bus.cfg_data[NI];
        end
      end
    end
  end

  // Cube enables: cleared on reset, set when a cube write carries a nonzero output mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= '0;
    end else if (cfg_take_c) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (bus.cfg_addr == AW'(NR + k)) begin
          en_q[k] <= (bus.cfg_data[2*NR+NO-1:2*NR] != '0);
        end
      end
    end
  end

  // Cube payload: only meaningful while its enable is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (cfg_take_c) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (bus.cfg_addr == AW'(NR + k)) begin
          care_q[k]  <= bus.cfg_data[NR-1:0];
          value_q[k] <= bus.cfg_data[2*NR-1:NR];
          omask_q[k] <= bus.cfg_data[2*NR+NO-1:2*NR];
        end
      end
    end
  end

  // Stage 1 datapath: GF(2) reduction of the input vector
  always_comb begin
    r_d = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      r_d[j] = (^(bus.x & mask_q[j])) ^ inv_q[j];
    end
  end

  // Stage 2 datapath: cube match and per-output OR plane
  always_comb begin
    hit_c = '0;
    y_d   = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      hit_c[k] = en_q[k] & (((r_q ^ value_q[k]) & care_q[k]) == '0);
    end
    for (int unsigned k = 0; k < NC; k++) begin
      y_d = y_d | (omask_q[k] & {NO{hit_c[k]}});
    end
  end

  // Stage 1 register: loads on accept, empties when its vector moves on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      r_q        <= '0;
    end else if (in_accept_c) begin
      s1_valid_q <= 1'b1;
      r_q        <= r_d;
    end else if (s2_adv_c) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 / output register: holds while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (s2_adv_c) begin
      out_valid_q <= 1'b1;
      y_q         <= y_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Completed-transfer counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_count_q <= '0;
    end else if (out_xfer_c) begin
      eval_count_q <= eval_count_q + CNT_W'(1);
    end
  end

endmodule
